mips_tlb: RTL and testbench
===========================

Name: mips_tlb

Overview:
- Parametrised successor to the fixed-mapping data address translator.
- Fully associative, MIPS32-style joint TLB with two lookup channels: instruction (i_) and data (d_).
- Also provides CP0 maintenance ports for TLBWI, TLBWR, TLBP and TLBR, plus a Random/Wired counter.
- Sits between the pipeline address-generation stages and the I/D caches. kseg0/kseg1 stay direct-mapped; kuseg, kseg2 and kseg3 are mapped through the TLB.

Parameters:
- TLB_ENTRIES, 16: entry count; power of two, 4..64. IDX_W = clog2(TLB_ENTRIES) is a localparam.
- K0_UNCACHED, 0: 1 makes kseg0 accesses report uncached.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- asid  in  8  current EntryHi.ASID from CP0.
- i_en  in  1  instruction-channel sample enable (0 = stall, hold outputs).
- i_vaddr  in  32  instruction virtual address.
- i_paddr  out  32  registered physical address.
- i_miss  out  1  no matching entry.
- i_invalid  out  1  matching entry has V=0.
- i_uncached  out  1  access must bypass cache.
- d_en  in  1  data-channel sample enable.
- d_vaddr  in  32  data virtual address.
- d_store  in  1  access is a store.
- d_paddr  out  32  registered physical address.
- d_miss  out  1  no matching entry.
- d_invalid  out  1  matching entry has V=0.
- d_modified  out  1  store to a page with D=0.
- d_uncached  out  1  access must bypass cache.
- tlb_we  in  1  write strobe.
- tlb_wr_random  in  1  with tlb_we: 1 = TLBWR (use random), 0 = TLBWI (use tlb_index).
- tlb_index  in  IDX_W  write/read index.
- entryhi  in  32  write/probe data: VPN2 = [31:13], ASID = [7:0].
- entrylo0  in  32  even page: PFN = [25:6], C = [5:3], D = [2], V = [1], G = [0].
- entrylo1  in  32  odd page, same layout.
- tlbp  in  1  probe strobe.
- probe_miss  out  1  registered probe result: no match.
- probe_index  out  IDX_W  registered index of matching entry.
- r_entryhi  out  32  combinational read of entry[tlb_index].
- r_entrylo0  out  32  combinational read of entry[tlb_index].
- r_entrylo1  out  32  combinational read of entry[tlb_index].
- wired_we  in  1  write Wired register.
- wired_data  in  IDX_W  new Wired value.
- random  out  IDX_W  current Random register.

Behaviour:
- Entry contents: VPN2[18:0], ASID[7:0], G, and per half PFN[19:0], C[2:0], D, V.
- Page size is fixed at 4 KB; there is no PageMask.
- On write, G = entrylo0.G & entrylo1.G. On read, G is replicated into bit 0 of both lo outputs; r_entryhi = {VPN2, 5'b0, ASID}.
- Reset (resetn = 0, asynchronous), every entry is cleared with V=0, D=0, G=0.
- Reset values: random = TLB_ENTRIES-1; wired = 0; all lookup outputs 0; probe_miss = 1; probe_index = 0.
- Lookup latency is 1 cycle. On a rising edge with x_en = 1, results for x_vaddr are registered. With x_en = 0 the previous results are held.
- Unmapped (vaddr[31:30] == 2'b10):
  - paddr = {3'b0, vaddr[28:0]}.
  - uncached = vaddr[29] | K0_UNCACHED.
  - miss, invalid and modified are all 0.
- Mapped:
  - An entry matches when VPN2 == vaddr[31:13] and (G or ASID == asid).
  - vaddr[12] selects the odd half.
  - paddr = {PFN, vaddr[11:0]}.
  - uncached = (C == 3'd2).
  - invalid = match & !V.
  - d_modified = match & V & !D & d_store.
  - On a miss, paddr is 0.
- Multiple matches (software error): the lowest index wins. There is no other side effect.
- Write: on the edge with tlb_we = 1, the target entry is replaced. The index is random if tlb_wr_random = 1, else tlb_index.
- A lookup or probe sampled on the same edge as a write sees the pre-write contents. The updated entry is visible from the next sample.
- Probe: on the edge with tlbp = 1, entryhi/asid matching is registered into probe_miss and probe_index (lowest matching index). The probe compares entryhi.ASID, not the asid port. Outputs hold until the next tlbp.
- Random: updates every cycle.
  - If wired_we = 1, next random = TLB_ENTRIES-1 and next wired = wired_data.
  - Else if random <= wired, next random = TLB_ENTRIES-1.
  - Else next random = random-1.
  - Random therefore never goes below wired. If wired >= TLB_ENTRIES-1, random is pinned at TLB_ENTRIES-1.
- TLBWR uses the random value present before the edge.
- Reset asserted mid-operation: all state returns to reset values immediately. No write in flight completes.

Test Plan:
- After reset: i_vaddr = 0x9FC00000 with i_en = 1 → next cycle i_paddr = 0x1FC00000, i_uncached = 0. Then d_vaddr = 0xBFAF8000 → d_paddr = 0x1FAF8000, d_uncached = 1.
- Mapped miss and hit:
  - Lookup d_vaddr = 0x00402004 → d_miss = 1.
  - TLBWI index 3 with entryhi = 0x00402005, entrylo0 = {PFN 0x12345, C = 3, D = 1, V = 1, G = 0}.
  - Next cycle same lookup → d_paddr = 0x12345004, d_miss = 0, d_uncached = 0.
  - Change asid to 6 → d_miss = 1.
- Invalid and modified:
  - Odd half written with V = 0; d_vaddr = 0x00403000 → d_invalid = 1.
  - Odd half with V = 1, D = 0 and d_store = 1 → d_modified = 1.
  - Same with d_store = 0 → d_modified = 0.
- Probe: tlbp with matching entryhi → probe_miss = 0, probe_index = 3. Non-matching entryhi → probe_miss = 1. TLBR index 3 → r_entryhi = 0x00402005.
- Random/Wired with TLB_ENTRIES = 16:
  - From reset, random counts 15, 14, … down to 0, then wraps to 15.
  - wired_we with 4 → next random = 15, sequence 15..4 then 15.
  - TLBWR writes the entry at the pre-edge random value.
- Same-edge write and lookup: the lookup reports the old miss, and the next sample hits. Asserting resetn = 0 mid-sequence clears all entries; the subsequent lookup misses.

Source files
------------

// File: rtl/mips_tlb.sv
// Fully associative MIPS32-style joint TLB: I/D lookup channels, CP0 write/probe/read, Random/Wired.
// Latency: lookups and probes register in 1 cycle; CP0 reads are combinational.
// Backpressure: none; x_en = 0 holds the channel's registered result.
module mips_tlb #(
    parameter int TLB_ENTRIES = 16,
    parameter int K0_UNCACHED = 0,
    localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       asid,
    input  logic             i_en,
    input  logic [31:0]      i_vaddr,
    output logic [31:0]      i_paddr,
    output logic             i_miss,
    output logic             i_invalid,
    output logic             i_uncached,
    input  logic             d_en,
    input  logic [31:0]      d_vaddr,
    input  logic             d_store,
    output logic [31:0]      d_paddr,
    output logic             d_miss,
    output logic             d_invalid,
    output logic             d_modified,
    output logic             d_uncached,
    input  logic             tlb_we,
    input  logic             tlb_wr_random,
    input  logic [IDX_W-1:0] tlb_index,
    input  logic [31:0]      entryhi,
    input  logic [31:0]      entrylo0,
    input  logic [31:0]      entrylo1,
    input  logic             tlbp,
    output logic             probe_miss,
    output logic [IDX_W-1:0] probe_index,
    output logic [31:0]      r_entryhi,
    output logic [31:0]      r_entrylo0,
    output logic [31:0]      r_entrylo1,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_data,
    output logic [IDX_W-1:0] random
);

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } half_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        half_t       lo0;
        half_t       lo1;
    } entry_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } match_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        miss;
        logic        invalid;
        logic        modified;
        logic        uncached;
    } res_t;

    entry_t           ent_q [TLB_ENTRIES];
    res_t             i_res_d, i_res_q, d_res_d, d_res_q;
    match_t           probe_d;
    logic             probe_miss_q;
    logic [IDX_W-1:0] probe_idx_q;
    logic [IDX_W-1:0] random_q, random_d, wired_q, wired_d, wr_idx;
    entry_t           new_ent;

    // Scan from the top down so the lowest matching index is the one that sticks.
    function automatic match_t find(input logic [18:0] vpn2, input logic [7:0] as);
        match_t m;
        m = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].vpn2 == vpn2 && (ent_q[i].g || ent_q[i].asid == as)) begin
                m.hit = 1'b1;
                m.idx = IDX_W'(i);
            end
        end
        return m;
    endfunction

    function automatic res_t lookup(input logic [31:0] va, input logic [7:0] as, input logic st);
        res_t   r;
        match_t m;
        half_t  h;
        r = '0;
        m = find(va[31:13], as);
        h = va[12] ? ent_q[m.idx].lo1 : ent_q[m.idx].lo0;
        if (va[31:30] == 2'b10) begin
            r.paddr    = {3'b000, va[28:0]};
            r.uncached = va[29] | (K0_UNCACHED != 0);
        end else if (m.hit) begin
            r.paddr    = {h.pfn, va[11:0]};
            r.uncached = (h.c == 3'd2);
            r.invalid  = !h.v;
            r.modified = h.v & !h.d & st;
        end else begin
            r.miss = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        i_res_d = lookup(i_vaddr, asid, 1'b0);
        d_res_d = lookup(d_vaddr, asid, d_store);
        probe_d = find(entryhi[31:13], entryhi[7:0]);
    end

    always_comb begin
        wr_idx           = tlb_wr_random ? random_q : tlb_index;
        new_ent          = '0;
        new_ent.vpn2     = entryhi[31:13];
        new_ent.asid     = entryhi[7:0];
        new_ent.g        = entrylo0[0] & entrylo1[0];
        new_ent.lo0      = {entrylo0[25:6], entrylo0[5:3], entrylo0[2], entrylo0[1]};
        new_ent.lo1      = {entrylo1[25:6], entrylo1[5:3], entrylo1[2], entrylo1[1]};
    end

    always_comb begin
        wired_d  = wired_q;
        random_d = random_q - IDX_W'(1);
        if (wired_we) begin
            random_d = RAND_TOP;
            wired_d  = wired_data;
        end else if (random_q <= wired_q) begin
            random_d = RAND_TOP;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            i_res_q      <= '0;
            d_res_q      <= '0;
            probe_miss_q <= 1'b1;
            probe_idx_q  <= '0;
            random_q     <= RAND_TOP;
            wired_q      <= '0;
        end else begin
            if (i_en) begin
                i_res_q <= i_res_d;
            end
            if (d_en) begin
                d_res_q <= d_res_d;
            end
            if (tlbp) begin
                probe_miss_q <= !probe_d.hit;
                probe_idx_q  <= probe_d.idx;
            end
            if (tlb_we) begin
                ent_q[wr_idx] <= new_ent;
            end
            random_q <= random_d;
            wired_q  <= wired_d;
        end
    end

    assign i_paddr     = i_res_q.paddr;
    assign i_miss      = i_res_q.miss;
    assign i_invalid   = i_res_q.invalid;
    assign i_uncached  = i_res_q.uncached;
    assign d_paddr     = d_res_q.paddr;
    assign d_miss      = d_res_q.miss;
    assign d_invalid   = d_res_q.invalid;
    assign d_modified  = d_res_q.modified;
    assign d_uncached  = d_res_q.uncached;
    assign probe_miss  = probe_miss_q;
    assign probe_index = probe_idx_q;
    assign random      = random_q;

    // G lives once per entry and is mirrored into both lo words on read.
    assign r_entryhi  = {ent_q[tlb_index].vpn2, 5'b00000, ent_q[tlb_index].asid};
    assign r_entrylo0 = {6'b000000, ent_q[tlb_index].lo0, ent_q[tlb_index].g};
    assign r_entrylo1 = {6'b000000, ent_q[tlb_index].lo1, ent_q[tlb_index].g};

    logic unused_bits;
    assign unused_bits = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26], i_res_q.modified};

endmodule

// File: tb/tb_mips_tlb.sv
// Self-checking bench for mips_tlb: directed scenarios plus randomized traffic against a table model.
module tb_mips_tlb;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    asid = '0;
    logic          i_en = 1'b0, d_en = 1'b0, d_store = 1'b0;
    logic [31:0]   i_vaddr = '0, d_vaddr = '0;
    logic [31:0]   i_paddr, d_paddr;
    logic          i_miss, i_invalid, i_uncached;
    logic          d_miss, d_invalid, d_modified, d_uncached;
    logic          tlb_we = 1'b0, tlb_wr_random = 1'b0, tlbp = 1'b0, wired_we = 1'b0;
    logic [IW-1:0] tlb_index = '0, wired_data = '0;
    logic [31:0]   entryhi = '0, entrylo0 = '0, entrylo1 = '0;
    logic          probe_miss;
    logic [IW-1:0] probe_index, random;
    logic [31:0]   r_entryhi, r_entrylo0, r_entrylo1;

    always #5 clk = ~clk;

    mips_tlb #(.TLB_ENTRIES(N), .K0_UNCACHED(0)) dut (
        .clk(clk), .resetn(resetn), .asid(asid),
        .i_en(i_en), .i_vaddr(i_vaddr), .i_paddr(i_paddr), .i_miss(i_miss),
        .i_invalid(i_invalid), .i_uncached(i_uncached),
        .d_en(d_en), .d_vaddr(d_vaddr), .d_store(d_store), .d_paddr(d_paddr),
        .d_miss(d_miss), .d_invalid(d_invalid), .d_modified(d_modified), .d_uncached(d_uncached),
        .tlb_we(tlb_we), .tlb_wr_random(tlb_wr_random), .tlb_index(tlb_index),
        .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1),
        .tlbp(tlbp), .probe_miss(probe_miss), .probe_index(probe_index),
        .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0), .r_entrylo1(r_entrylo1),
        .wired_we(wired_we), .wired_data(wired_data), .random(random)
    );

    int n_pass = 0, n_total = 0;

    // Reference model: one row per entry, two halves per row.
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g    [N];
    logic [19:0] m_pfn  [N][2];
    logic [2:0]  m_c    [N][2];
    logic        m_d    [N][2];
    logic        m_v    [N][2];
    int          m_rand, m_wired;
    logic [31:0] e_i_pa, e_d_pa;
    logic        e_i_miss, e_i_inv, e_i_unc, e_i_mod;
    logic        e_d_miss, e_d_inv, e_d_mod, e_d_unc, e_pmiss;
    int          e_pidx;
    logic [18:0] pool [8];

    function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] as);
        for (int i = 0; i < N; i++)
            if (m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == as)) return i;
        return -1;
    endfunction

    function automatic void m_lookup(input logic [31:0] va, input logic [7:0] as, input logic st,
                                     output logic [31:0] pa, output logic miss, output logic inv,
                                     output logic modf, output logic unc);
        int k, h;
        pa = 0; miss = 0; inv = 0; modf = 0; unc = 0;
        if (va[31:30] == 2'b10) begin
            pa  = va & 32'h1FFF_FFFF;
            unc = va[29];
        end else begin
            k = m_find(va[31:13], as);
            if (k < 0) miss = 1;
            else begin
                h    = int'(va[12]);
                pa   = {m_pfn[k][h], va[11:0]};
                unc  = (m_c[k][h] == 3'd2);
                inv  = !m_v[k][h];
                modf = m_v[k][h] && !m_d[k][h] && st;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = 0; m_asid[i] = 0; m_g[i] = 0;
            for (int h = 0; h < 2; h++) begin
                m_pfn[i][h] = 0; m_c[i][h] = 0; m_d[i][h] = 0; m_v[i][h] = 0;
            end
        end
        m_rand = N - 1; m_wired = 0;
        {e_i_pa, e_i_miss, e_i_inv, e_i_unc, e_i_mod} = '0;
        {e_d_pa, e_d_miss, e_d_inv, e_d_mod, e_d_unc} = '0;
        e_pmiss = 1; e_pidx = 0;
    endtask

    // Applies one clock edge's worth of rules to the model using the inputs now being driven.
    task automatic model_update();
        int k, w;
        if (i_en) m_lookup(i_vaddr, asid, 1'b0, e_i_pa, e_i_miss, e_i_inv, e_i_mod, e_i_unc);
        if (d_en) m_lookup(d_vaddr, asid, d_store, e_d_pa, e_d_miss, e_d_inv, e_d_mod, e_d_unc);
        if (tlbp) begin
            k = m_find(entryhi[31:13], entryhi[7:0]);
            e_pmiss = (k < 0);
            if (k >= 0) e_pidx = k;
        end
        if (tlb_we) begin
            w = tlb_wr_random ? m_rand : int'(tlb_index);
            m_vpn2[w] = entryhi[31:13]; m_asid[w] = entryhi[7:0];
            m_g[w] = entrylo0[0] & entrylo1[0];
            m_pfn[w][0] = entrylo0[25:6]; m_c[w][0] = entrylo0[5:3];
            m_d[w][0] = entrylo0[2]; m_v[w][0] = entrylo0[1];
            m_pfn[w][1] = entrylo1[25:6]; m_c[w][1] = entrylo1[5:3];
            m_d[w][1] = entrylo1[2]; m_v[w][1] = entrylo1[1];
        end
        if (wired_we) begin m_rand = N - 1; m_wired = int'(wired_data); end
        else if (m_rand <= m_wired) m_rand = N - 1;
        else m_rand = m_rand - 1;
    endtask

    task automatic step();
        if (resetn) model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tlb_we = 0; tlb_wr_random = 0; tlbp = 0; wired_we = 0; d_store = 0;
    endtask

    task automatic test_reset();
        resetn = 0; idle(); model_reset();
        i_en = 1; d_en = 1; i_vaddr = 32'h9FC0_0000; d_vaddr = 32'hBFC0_0000;
        step(); step();
        n_total++;
        if ({i_paddr, i_miss, i_invalid, i_uncached, d_paddr, d_miss, d_invalid, d_modified, d_uncached} !== '0)
            $display("FAIL reset_lookup: got i=%h d=%h flags=%b%b%b %b%b%b%b exp all zero", i_paddr, d_paddr,
                     i_miss, i_invalid, i_uncached, d_miss, d_invalid, d_modified, d_uncached);
        else n_pass++;
        n_total++;
        if (probe_miss !== 1'b1 || probe_index !== 4'd0 || random !== 4'd15)
            $display("FAIL reset_cp0: got pmiss=%b pidx=%0d rnd=%0d exp 1 0 15", probe_miss, probe_index, random);
        else n_pass++;
        i_en = 0; d_en = 0;
        resetn = 1;
    endtask

    task automatic test_unmapped();
        i_en = 1; i_vaddr = 32'h9FC0_0000; step();
        n_total++;
        if (i_paddr !== 32'h1FC0_0000 || i_uncached !== 1'b0 || i_miss !== 1'b0)
            $display("FAIL kseg0_i: got pa=%h unc=%b miss=%b exp 1fc00000 0 0", i_paddr, i_uncached, i_miss);
        else n_pass++;
        d_en = 1; d_vaddr = 32'hBFAF_8000; step();
        n_total++;
        if (d_paddr !== 32'h1FAF_8000 || d_uncached !== 1'b1 || d_miss !== 1'b0)
            $display("FAIL kseg1_d: got pa=%h unc=%b miss=%b exp 1faf8000 1 0", d_paddr, d_uncached, d_miss);
        else n_pass++;
        i_en = 0; i_vaddr = 32'hBFC0_1000; step();
        n_total++;
        if (i_paddr !== 32'h1FC0_0000 || i_uncached !== 1'b0)
            $display("FAIL i_hold: got pa=%h unc=%b exp 1fc00000 0", i_paddr, i_uncached);
        else n_pass++;
    endtask

    task automatic test_map();
        asid = 8'd5; d_en = 1; d_store = 0; d_vaddr = 32'h0040_2004; step();
        n_total++;
        if (d_miss !== 1'b1 || d_paddr !== 32'h0)
            $display("FAIL map_cold_miss: got miss=%b pa=%h exp 1 0", d_miss, d_paddr);
        else n_pass++;
        tlb_we = 1; tlb_wr_random = 0; tlb_index = 4'd3;
        entryhi = 32'h0040_2005; entrylo0 = 32'h0048_D15E; entrylo1 = 32'h0001_DDD0;
        step();
        n_total++;
        if (d_miss !== 1'b1)
            $display("FAIL same_edge_write: got miss=%b exp 1", d_miss);
        else n_pass++;
        tlb_we = 0; step();
        n_total++;
        if (d_paddr !== 32'h1234_5004 || d_miss !== 1'b0 || d_uncached !== 1'b0 || d_invalid !== 1'b0)
            $display("FAIL map_hit: got pa=%h miss=%b unc=%b inv=%b exp 12345004 0 0 0",
                     d_paddr, d_miss, d_uncached, d_invalid);
        else n_pass++;
        asid = 8'd6; step();
        n_total++;
        if (d_miss !== 1'b1) $display("FAIL asid_mismatch: got miss=%b exp 1", d_miss);
        else n_pass++;
        asid = 8'd5; d_vaddr = 32'h0040_3000; step();
        n_total++;
        if (d_invalid !== 1'b1 || d_miss !== 1'b0 || d_modified !== 1'b0)
            $display("FAIL odd_invalid: got inv=%b miss=%b mod=%b exp 1 0 0", d_invalid, d_miss, d_modified);
        else n_pass++;
        tlb_we = 1; entrylo1 = 32'h0001_DDD2; step();
        tlb_we = 0; d_store = 1; step();
        n_total++;
        if (d_modified !== 1'b1 || d_invalid !== 1'b0 || d_paddr !== 32'h0077_7000 || d_uncached !== 1'b1)
            $display("FAIL store_clean: got mod=%b inv=%b pa=%h unc=%b exp 1 0 00777000 1",
                     d_modified, d_invalid, d_paddr, d_uncached);
        else n_pass++;
        d_store = 0; step();
        n_total++;
        if (d_modified !== 1'b0) $display("FAIL load_clean: got mod=%b exp 0", d_modified);
        else n_pass++;
        tlbp = 1; entryhi = 32'h0040_2005; step();
        tlbp = 0;
        n_total++;
        if (probe_miss !== 1'b0 || probe_index !== 4'd3)
            $display("FAIL probe_hit: got pmiss=%b pidx=%0d exp 0 3", probe_miss, probe_index);
        else n_pass++;
        tlbp = 1; entryhi = 32'h0040_2006; step();
        tlbp = 0; step();
        n_total++;
        if (probe_miss !== 1'b1) $display("FAIL probe_miss: got pmiss=%b exp 1", probe_miss);
        else n_pass++;
        tlb_index = 4'd3; #1;
        n_total++;
        if (r_entryhi !== 32'h0040_2005 || r_entrylo0 !== 32'h0048_D15E || r_entrylo1 !== 32'h0001_DDD2)
            $display("FAIL tlbr: got %h %h %h exp 00402005 0048d15e 0001ddd2", r_entryhi, r_entrylo0, r_entrylo1);
        else n_pass++;
        d_en = 0;
    endtask

    task automatic test_random_wired();
        int ex;
        resetn = 0; idle(); model_reset(); #2;
        resetn = 1; #1;
        n_total++;
        if (random !== 4'd15) $display("FAIL rand_start: got %0d exp 15", random);
        else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            step();
            ex = (k == 16) ? 15 : 15 - k;
            n_total++;
            if (random !== IW'(ex)) $display("FAIL rand_count k=%0d: got %0d exp %0d", k, random, ex);
            else n_pass++;
        end
        wired_we = 1; wired_data = 4'd4; step();
        wired_we = 0;
        n_total++;
        if (random !== 4'd15) $display("FAIL wired_load: got %0d exp 15", random);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            step();
            ex = (k <= 11) ? 15 - k : 15;
            n_total++;
            if (random !== IW'(ex)) $display("FAIL wired_count k=%0d: got %0d exp %0d", k, random, ex);
            else n_pass++;
        end
        tlb_we = 1; tlb_wr_random = 1; tlb_index = 4'd0;
        entryhi = 32'hFFFF_E011; entrylo0 = 32'h2; entrylo1 = 32'h2; step();
        tlb_we = 0; tlb_wr_random = 0;
        tlbp = 1; step();
        tlbp = 0;
        n_total++;
        if (probe_miss !== 1'b0 || probe_index !== 4'd15)
            $display("FAIL tlbwr_slot: got pmiss=%b pidx=%0d exp 0 15", probe_miss, probe_index);
        else n_pass++;
        wired_we = 1; wired_data = 4'd15; step();
        wired_we = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (random !== 4'd15) $display("FAIL wired_pinned k=%0d: got %0d exp 15", k, random);
            else n_pass++;
        end
        wired_we = 1; wired_data = 4'd0; step();
        wired_we = 0;
    endtask

    task automatic test_reset_mid();
        asid = 8'd5; tlb_we = 1; tlb_index = 4'd2;
        entryhi = 32'h0040_2005; entrylo0 = 32'h0048_D15E; entrylo1 = 32'h0; step();
        tlb_we = 0; d_en = 1; d_vaddr = 32'h0040_2004; step();
        n_total++;
        if (d_paddr !== 32'h1234_5004 || d_miss !== 1'b0)
            $display("FAIL pre_reset_hit: got pa=%h miss=%b exp 12345004 0", d_paddr, d_miss);
        else n_pass++;
        #3 resetn = 0; model_reset();
        #1;
        n_total++;
        if (d_paddr !== 32'h0 || d_miss !== 1'b0 || random !== 4'd15 || probe_miss !== 1'b1)
            $display("FAIL async_reset: got pa=%h miss=%b rnd=%0d pmiss=%b exp 0 0 15 1",
                     d_paddr, d_miss, random, probe_miss);
        else n_pass++;
        #2 resetn = 1;
        step();
        n_total++;
        if (d_miss !== 1'b1 || d_paddr !== 32'h0)
            $display("FAIL post_reset_miss: got miss=%b pa=%h exp 1 0", d_miss, d_paddr);
        else n_pass++;
        d_en = 0;
    endtask

    function automatic logic [31:0] rand_va();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return {pool[$urandom_range(0, 7)], 13'($urandom)};
    endfunction

    task automatic test_random_traffic();
        for (int i = 0; i < 8; i++) begin
            pool[i] = 19'($urandom);
            if (pool[i][18:17] == 2'b10) pool[i][18] = 1'b0;
        end
        for (int it = 0; it < 400; it++) begin
            asid          = 8'($urandom_range(1, 3));
            i_en          = ($urandom_range(0, 3) != 0);
            d_en          = ($urandom_range(0, 3) != 0);
            d_store       = 1'($urandom);
            i_vaddr       = rand_va();
            d_vaddr       = rand_va();
            tlb_we        = ($urandom_range(0, 3) == 0);
            tlb_wr_random = 1'($urandom);
            tlb_index     = IW'($urandom);
            entryhi       = {pool[$urandom_range(0, 7)], 5'b0, 8'($urandom_range(1, 3))};
            entrylo0      = $urandom & 32'h03FF_FFFF;
            entrylo1      = $urandom & 32'h03FF_FFFF;
            tlbp          = ($urandom_range(0, 2) == 0);
            wired_we      = ($urandom_range(0, 19) == 0);
            wired_data    = IW'($urandom);
            step();
            n_total++;
            if ({i_paddr, i_miss, i_invalid, i_uncached} !== {e_i_pa, e_i_miss, e_i_inv, e_i_unc})
                $display("FAIL rnd_i it=%0d: got %h/%b%b%b exp %h/%b%b%b", it, i_paddr, i_miss, i_invalid,
                         i_uncached, e_i_pa, e_i_miss, e_i_inv, e_i_unc);
            else n_pass++;
            n_total++;
            if ({d_paddr, d_miss, d_invalid, d_modified, d_uncached} !== {e_d_pa, e_d_miss, e_d_inv, e_d_mod, e_d_unc})
                $display("FAIL rnd_d it=%0d: got %h/%b%b%b%b exp %h/%b%b%b%b", it, d_paddr, d_miss, d_invalid,
                         d_modified, d_uncached, e_d_pa, e_d_miss, e_d_inv, e_d_mod, e_d_unc);
            else n_pass++;
            n_total++;
            if (probe_miss !== e_pmiss || (!e_pmiss && probe_index !== IW'(e_pidx)))
                $display("FAIL rnd_probe it=%0d: got %b/%0d exp %b/%0d", it, probe_miss, probe_index, e_pmiss, e_pidx);
            else n_pass++;
            n_total++;
            if (random !== IW'(m_rand)) $display("FAIL rnd_random it=%0d: got %0d exp %0d", it, random, m_rand);
            else n_pass++;
            n_total++;
            if (r_entryhi !== {m_vpn2[tlb_index], 5'b0, m_asid[tlb_index]} ||
                r_entrylo0 !== {6'b0, m_pfn[tlb_index][0], m_c[tlb_index][0], m_d[tlb_index][0], m_v[tlb_index][0], m_g[tlb_index]} ||
                r_entrylo1 !== {6'b0, m_pfn[tlb_index][1], m_c[tlb_index][1], m_d[tlb_index][1], m_v[tlb_index][1], m_g[tlb_index]})
                $display("FAIL rnd_tlbr it=%0d idx=%0d: got %h %h %h", it, tlb_index, r_entryhi, r_entrylo0, r_entrylo1);
            else n_pass++;
        end
        idle(); i_en = 0; d_en = 0;
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_map();
        test_random_wired();
        test_reset_mid();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
